// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - byte FIFO from uart_rx replayed to uart_tx with optional CR->CRLF expansion
module uart_echo_responder #(
   parameter int DEPTH_LOG2   = 4,
   parameter int CRLF         = 1,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_ready,
   input  logic [7:0]            rx_data,
   input  logic                  tx_busy,
   output logic                  tx_send,
   output logic [7:0]            tx_data,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  overflow
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int TW    = $clog2(BUSY_TIMEOUT + 2);
   localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [TW-1:0]       TMO_LAST = TW'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

   state_t                state_q, state_d;
   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  tx_send_q, tx_send_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  lf_pending_q, lf_pending_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  wr_en;
   logic                  pop;
   logic [7:0]            head;

   always_comb begin
      // A pop in the same cycle never frees space for a write at full
      wr_en      = rx_ready && (count_q != FULL);
      pop        = (state_q == IDLE) && (count_q != '0) && !tx_busy;
      head       = mem_q[rd_ptr_q];
      wr_ptr_d   = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
      overflow_d = overflow_q || (rx_ready && !wr_en);
      count_d    = count_q;
      if (wr_en && !pop) begin
         count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      end else if (pop && !wr_en) begin
         count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      end

      state_d      = state_q;
      tx_data_d    = tx_data_q;
      lf_pending_d = lf_pending_q;
      tmo_d        = tmo_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               tx_data_d    = head;
               lf_pending_d = (CRLF == 1) && (head == 8'h0D);
               state_d      = SEND;
            end
         end
         SEND: begin
            tmo_d   = '0;
            state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (tx_busy || (tmo_q == TMO_LAST)) begin
               state_d = WAIT_LO;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               if (lf_pending_q) begin
                  tx_data_d    = 8'h0A;
                  lf_pending_d = 1'b0;
                  state_d      = SEND;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      tx_send_d = (state_d == SEND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         tx_send_q    <= 1'b0;
         tx_data_q    <= 8'h00;
         lf_pending_q <= 1'b0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         tx_send_q    <= tx_send_d;
         tx_data_q    <= tx_data_d;
         lf_pending_q <= lf_pending_d;
         tmo_q        <= tmo_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   assign tx_send    = tx_send_q;
   assign tx_data    = tx_data_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - randomized self-checking bench for uart_echo_responder
module tb_uart_echo_responder;
   localparam int TMO = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       rx_ready [2] = '{1'b0, 1'b0};
   logic [7:0] rx_data  [2] = '{8'h00, 8'h00};
   logic       force_hi [2] = '{1'b0, 1'b0};
   int         bcnt     [2] = '{0, 0};
   int         hold     [2] = '{20, 20};
   logic       busy_a, busy_b;
   logic       tx_send_a, tx_send_b, ovf_a, ovf_b;
   logic [7:0] tx_data_a, tx_data_b;
   logic [4:0] cnt_a;
   logic [2:0] cnt_b;

   assign busy_a = force_hi[0] | (bcnt[0] != 0);
   assign busy_b = force_hi[1] | (bcnt[1] != 0);

   uart_echo_responder #(.DEPTH_LOG2(4), .CRLF(1), .BUSY_TIMEOUT(TMO)) dut_a (
      .clk(clk), .rst(rst), .rx_ready(rx_ready[0]), .rx_data(rx_data[0]), .tx_busy(busy_a),
      .tx_send(tx_send_a), .tx_data(tx_data_a), .fifo_count(cnt_a), .overflow(ovf_a));

   uart_echo_responder #(.DEPTH_LOG2(2), .CRLF(0), .BUSY_TIMEOUT(TMO)) dut_b (
      .clk(clk), .rst(rst), .rx_ready(rx_ready[1]), .rx_data(rx_data[1]), .tx_busy(busy_b),
      .tx_send(tx_send_b), .tx_data(tx_data_b), .fifo_count(cnt_b), .overflow(ovf_b));

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] obs_q [2][$];
   logic [7:0] exp_q [2][$];
   logic [7:0] stim_q [$];
   int   send_cnt  [2] = '{0, 0};
   int   pulse_err [2] = '{0, 0};
   int   busy_err  [2] = '{0, 0};
   int   t_prev    [2] = '{0, 0};
   int   t_last    [2] = '{0, 0};
   logic prev_send [2] = '{1'b0, 1'b0};
   logic prev_busy [2] = '{1'b0, 1'b0};
   logic send_seen [2] = '{1'b0, 1'b0};
   int   cyc = 0;

   function automatic logic send_of(input int i);
      return (i == 0) ? tx_send_a : tx_send_b;
   endfunction
   function automatic logic [7:0] data_of(input int i);
      return (i == 0) ? tx_data_a : tx_data_b;
   endfunction
   function automatic logic [31:0] cnt_of(input int i);
      return (i == 0) ? 32'(cnt_a) : 32'(cnt_b);
   endfunction
   function automatic logic ovf_of(input int i);
      return (i == 0) ? ovf_a : ovf_b;
   endfunction
   function automatic logic busy_of(input int i);
      return (i == 0) ? busy_a : busy_b;
   endfunction
   function automatic int depth_of(input int i);
      return (i == 0) ? 16 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // uart_tx stand-in: records every send and holds busy for hold[i] cycles
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            send_seen[i] = (send_of(i) === 1'b1);
            if (send_seen[i]) begin
               obs_q[i].push_back(data_of(i));
               send_cnt[i]++;
               t_prev[i] = t_last[i];
               t_last[i] = cyc;
               if (prev_send[i]) pulse_err[i]++;
               if (prev_busy[i]) busy_err[i]++;
            end
            prev_send[i] = send_seen[i];
            prev_busy[i] = (busy_of(i) === 1'b1);
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (send_seen[i]) bcnt[i] = hold[i];
            else if (bcnt[i] > 0) bcnt[i]--;
         end
      end
   end

   // Expected output stream: accepted bytes in order, CR followed by LF on the CRLF unit
   task automatic expect_bytes(input int i, input int cap);
      int occ = 0;
      foreach (stim_q[k]) begin
         if (occ < cap) begin
            occ++;
            exp_q[i].push_back(stim_q[k]);
            if (i == 0 && stim_q[k] == 8'h0D) exp_q[i].push_back(8'h0A);
         end
      end
   endtask

   task automatic rx_bytes(input int i, input int max_gap);
      int gap;
      foreach (stim_q[k]) begin
         @(posedge clk);
         #1;
         rx_ready[i] = 1'b1;
         rx_data[i]  = stim_q[k];
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         if (gap > 0) begin
            @(posedge clk);
            #1;
            rx_ready[i] = 1'b0;
            repeat (gap - 1) @(posedge clk);
         end
      end
      @(posedge clk);
      #1;
      rx_ready[i] = 1'b0;
   endtask

   task automatic drain(input int i);
      int quiet = 0;
      for (int c = 0; c < 4000 && quiet < 30; c++) begin
         @(negedge clk);
         if (cnt_of(i) == 0 && busy_of(i) == 1'b0 && send_of(i) == 1'b0) quiet++;
         else quiet = 0;
      end
      check($sformatf("drain%0d", i), 32'(quiet >= 30), 1);
   endtask

   task automatic compare_stream(input int i, input string tag);
      check({tag, "_len"}, obs_q[i].size(), exp_q[i].size());
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++)
         check($sformatf("%s_byte%0d", tag, k), 32'(obs_q[i][k]), 32'(exp_q[i][k]));
      obs_q[i].delete();
      exp_q[i].delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      int snap;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_send%0d", i), 32'(send_of(i)), 0);
         check($sformatf("rst_data%0d", i), 32'(data_of(i)), 0);
         check($sformatf("rst_cnt%0d", i), cnt_of(i), 0);
         check($sformatf("rst_ovf%0d", i), 32'(ovf_of(i)), 0);
      end

      // Single byte: count 1 next cycle, send two cycles after the pulse
      stim_q = '{8'h2A};
      expect_bytes(0, 1000);
      @(posedge clk);
      #1;
      rx_ready[0] = 1'b1;
      rx_data[0]  = 8'h2A;
      @(negedge clk);
      check("t1_cnt_n", cnt_of(0), 0);
      @(posedge clk);
      #1;
      rx_ready[0] = 1'b0;
      @(negedge clk);
      check("t1_cnt_n1", cnt_of(0), 1);
      check("t1_send_n1", 32'(send_of(0)), 0);
      @(negedge clk);
      check("t1_send_n2", 32'(send_of(0)), 1);
      check("t1_data_n2", 32'(data_of(0)), 32'h2A);
      check("t1_cnt_n2", cnt_of(0), 0);
      @(negedge clk);
      check("t1_send_n3", 32'(send_of(0)), 0);
      drain(0);
      compare_stream(0, "t1");

      // Ordered burst while busy
      force_hi[0] = 1'b1;
      stim_q = '{8'h41, 8'h42, 8'h43};
      expect_bytes(0, 1000);
      rx_bytes(0, 0);
      @(negedge clk);
      check("t2_cnt", cnt_of(0), 3);
      repeat (5) @(posedge clk);
      #1;
      force_hi[0] = 1'b0;
      drain(0);
      compare_stream(0, "t2");

      // CR expansion on unit A only
      stim_q = '{8'h0D, 8'h58};
      for (int i = 0; i < 2; i++) begin
         expect_bytes(i, 1000);
         rx_bytes(i, 0);
      end
      drain(0);
      drain(1);
      compare_stream(0, "t3_crlf1");
      compare_stream(1, "t3_crlf0");

      // Overflow on the depth-4 unit, then a write in the pop cycle at full
      force_hi[1] = 1'b1;
      stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      expect_bytes(1, 4);
      rx_bytes(1, 0);
      @(negedge clk);
      check("t4_cnt_full", cnt_of(1), 4);
      check("t4_ovf", 32'(ovf_of(1)), 1);
      check("t4_ovf_other", 32'(ovf_of(0)), 0);
      @(posedge clk);
      #1;
      force_hi[1] = 1'b0;
      rx_ready[1] = 1'b1;
      rx_data[1]  = 8'h06;
      @(posedge clk);
      #1;
      rx_ready[1] = 1'b0;
      @(negedge clk);
      check("t4_cnt_pop_at_full", cnt_of(1), 3);
      drain(1);
      compare_stream(1, "t4");
      check("t4_ovf_sticky", 32'(ovf_of(1)), 1);

      // Busy never rises: timeout path, plus write landing on a pop
      hold[0] = 0;
      stim_q = '{8'h33, 8'h34};
      expect_bytes(0, 1000);
      rx_bytes(0, 0);
      @(negedge clk);
      check("t5_cnt_wr_pop", cnt_of(0), 1);
      drain(0);
      check("t5_gap", 32'(t_last[0] - t_prev[0]), 32'(TMO + 4));
      compare_stream(0, "t5");
      hold[0] = 20;

      // Reset while waiting for busy to fall with three bytes queued
      stim_q = '{8'h61, 8'h62, 8'h63, 8'h64};
      rx_bytes(0, 0);
      repeat (5) @(negedge clk);
      check("t6_queued", cnt_of(0), 3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_send", 32'(send_of(0)), 0);
      check("t6_data", 32'(data_of(0)), 0);
      check("t6_cnt", cnt_of(0), 0);
      check("t6_ovf_b", 32'(ovf_of(1)), 0);
      snap = send_cnt[0];
      repeat (60) @(negedge clk);
      check("t6_no_send", 32'(send_cnt[0]), 32'(snap));
      exp_q[0].push_back(8'h61);
      compare_stream(0, "t6");

      // Random bursts within capacity, random busy length and gaps
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 2; i++) begin
            hold[i] = int'($urandom_range(0, 25));
            n = int'($urandom_range(1, depth_of(i)));
            stim_q.delete();
            for (int k = 0; k < n; k++)
               stim_q.push_back(($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom));
            expect_bytes(i, 1000);
            rx_bytes(i, 3);
            drain(i);
            compare_stream(i, $sformatf("rnd%0d_%0d", r, i));
         end
      end

      for (int i = 0; i < 2; i++) begin
         check($sformatf("pulse_width%0d", i), 32'(pulse_err[i]), 0);
         check($sformatf("send_after_busy%0d", i), 32'(busy_err[i]), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Byte-level responder between the `uart_rx` receive side and the `uart_tx` transmit side. It takes each byte `uart_rx` presents on its `ready`/`data` outputs and stores it in a small FIFO. It then replays the bytes in order to `uart_tx` through the `send`/`data`/`busy` handshake, optionally expanding CR to CR LF. It is the far end of the link that the transmitter drives and is used for loopback bring-up and as a terminal echo.

## Interface

**Parameters**

- `DEPTH_LOG2`, default 4. FIFO depth is 2^DEPTH_LOG2 bytes.
- `CRLF`, default 1. When 1, a transmitted 0x0D is followed automatically by 0x0A.
- `BUSY_TIMEOUT`, default 15. Number of cycles to wait for `tx_busy` to rise after a send pulse before the byte is treated as accepted.

**Ports**

- `clk`, input, 1. Single clock for the whole block.
- `rst`, input, 1. Reset; synchronous, active-high.
- `rx_ready`, input, 1. One-cycle pulse from `uart_rx`; `rx_data` is valid in that cycle.
- `rx_data`, input, 8. Received byte.
- `tx_busy`, input, 1. `uart_tx` busy flag.
- `tx_send`, output, 1. One-cycle send pulse to `uart_tx`.
- `tx_data`, output, 8. Byte to transmit; held stable from the `tx_send` cycle until the block returns to IDLE.
- `fifo_count`, output, DEPTH_LOG2+1. Current number of bytes stored.
- `overflow`, output, 1. Sticky flag: a byte was dropped because the FIFO was full.

## Operation

**FIFO**
- Circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo depth.
- `fifo_count` is a separate register.
- Write: `rx_ready`=1 and count<depth. Store the byte at the write pointer, then increment the pointer.
- Write while full (count==depth): the byte is discarded, `overflow` is set to 1, and pointers and count are unchanged.
- Pop: performed only by the FSM when leaving IDLE.
- Write and pop in the same cycle: both take effect and count is unchanged. At count==depth a same-cycle pop does NOT make room; the write is still dropped.

**FSM states:** IDLE, SEND, WAIT_HI, WAIT_LO.

- **IDLE**
  - If count>0 and `tx_busy`=0: pop the head byte into `tx_data`, set `lf_pending` = (CRLF==1 && byte==0x0D), go to SEND.
  - Otherwise stay in IDLE.
- **SEND**
  - `tx_send`=1 for this cycle only. Clear the timeout counter and go to WAIT_HI.
- **WAIT_HI**
  - If `tx_busy`=1: go to WAIT_LO.
  - Else if the timeout counter reaches BUSY_TIMEOUT: go to WAIT_LO. WAIT_LO then exits immediately because busy is low.
  - Otherwise increment the counter.
- **WAIT_LO**
  - Wait for `tx_busy`=0.
  - When it is 0 and `lf_pending`=1: load 0x0A into `tx_data`, clear `lf_pending`, go to SEND. The FIFO is not popped.
  - When it is 0 and `lf_pending`=0: go to IDLE.

**Reset values**
- `tx_send`=0, `tx_data`=0x00, `fifo_count`=0, `overflow`=0.
- Pointers=0, state=IDLE, `lf_pending`=0.
- Reset mid-transfer aborts immediately. FIFO contents are discarded and no further `tx_send` is issued. A `uart_tx` frame already in flight completes on its own.

## Timing

- All outputs are registered.
- `rx_ready` high in cycle n into an empty FIFO with `tx_busy`=0:
  - `fifo_count`=1 in cycle n+1.
  - State is SEND and `tx_send`=1 in cycle n+2, with `fifo_count` back to 0.
- Minimum gap between consecutive `tx_send` pulses is 4 cycles (SEND→WAIT_HI→WAIT_LO→IDLE→SEND), given that busy rises and falls within one cycle each. The CR→LF back-to-back gap is 3 cycles (no IDLE visit).
- `tx_send` is never asserted while `tx_busy`=1 was sampled in the preceding IDLE or WAIT_LO cycle.
- The overflow flag sets in the cycle after the dropped `rx_ready` and clears only on `rst`.

## Test plan

1. **Single byte.** Reset, then pulse `rx_ready` with 0x2A. Required: `tx_send` is high for exactly 1 cycle, 2 cycles after the pulse, with `tx_data`=0x2A. The bench model holds busy for 20 cycles, and `fifo_count` returns to 0.
2. **Ordered burst.** Pulse 0x41, 0x42, 0x43 on consecutive cycles while busy is high. Required: `fifo_count` reaches 3, and the sends then occur in the order 0x41, 0x42, 0x43, one per busy-low window.
3. **CRLF.** With CRLF=1, receive 0x0D then 0x58. Required: the transmitted sequence is 0x0D, 0x0A, 0x58. With CRLF=0 the sequence is 0x0D, 0x58.
4. **Overflow.** With DEPTH_LOG2=2 and busy held high, write 5 bytes 0x01–0x05. Required: `fifo_count`=4 and `overflow`=1. After busy is released the output is 0x01–0x04, and 0x05 is never sent.
5. **Busy timeout and simultaneous write/pop.** Busy tied to 0: each byte still completes after BUSY_TIMEOUT+1 cycles in WAIT_HI. A write landing in the same cycle as a pop leaves `fifo_count` unchanged.
6. **Reset mid-frame.** Assert `rst` for 1 cycle during WAIT_LO with 3 bytes queued. Required: all outputs take their reset values the next cycle, and no `tx_send` occurs afterward without new `rx_ready` input.
